// File: rtl/pipelined_barrel_shifter.sv
// log2(WIDTH)-stage SLL/SRL/SRA/ROTL shifter, one register per stage, valid/ready on both ends.
// Optional zero flag on the result is built when SHIFTER_ZERO_FLAG_EN is defined.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
`ifdef SHIFTER_ZERO_FLAG_EN
    ,
    output logic               out_zero
`endif
);

    logic stall;
    logic advance;

    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] mode,
                                                  input int amt);
        case (mode)
            2'b00:   return d << amt;
            2'b01:   return d >> amt;
            2'b10:   return $signed(d) >>> amt;
            default: return (d << amt) | (d >> (WIDTH - amt));
        endcase
    endfunction

    // Whole pipe freezes on output backpressure, so bubbles keep their slot.
    assign stall   = out_valid && !out_ready;
    assign advance = !stall;
    assign in_ready = !stall;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic               shift_en;
        logic               v_in;
        logic [WIDTH-1:0]   d_in;
        logic [1:0]         m_in;
        logic [TAG_W-1:0]   t_in;
        logic [WIDTH-1:0]   shifted;
        logic               q_valid;
        logic [WIDTH-1:0]   q_data;
        logic [TAG_W-1:0]   q_tag;

        if (k == 0) begin : g_src
            assign shift_en = in_shamt[0];
            assign v_in     = in_valid;
            assign d_in     = in_data;
            assign m_in     = in_mode;
            assign t_in     = in_tag;
        end else begin : g_src
            assign shift_en = g_stage[k-1].g_mid.q_shamt[0];
            assign v_in     = g_stage[k-1].q_valid;
            assign d_in     = g_stage[k-1].q_data;
            assign m_in     = g_stage[k-1].g_mid.q_mode;
            assign t_in     = g_stage[k-1].q_tag;
        end

        assign shifted = shift_en ? shift_by(d_in, m_in, 1 << k) : d_in;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                q_valid <= 1'b0;
                q_data  <= '0;
                q_tag   <= '0;
            end else if (advance) begin
                q_valid <= v_in;
                if (v_in) begin
                    q_data <= shifted;
                    q_tag  <= t_in;
                end
            end
        end

        // Only the not-yet-consumed shamt bits travel on; the last stage needs no mode/shamt.
        if (k < SHAMT_W - 1) begin : g_mid
            localparam int RW = SHAMT_W - 1 - k;
            logic [RW-1:0] rest;
            logic [RW-1:0] q_shamt;
            logic [1:0]    q_mode;

            if (k == 0) begin : g_rest
                assign rest = in_shamt[SHAMT_W-1:1];
            end else begin : g_rest
                assign rest = g_stage[k-1].g_mid.q_shamt[RW:1];
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    q_shamt <= '0;
                    q_mode  <= '0;
                end else if (advance && v_in) begin
                    q_shamt <= rest;
                    q_mode  <= m_in;
                end
            end
        end
    end

    assign out_valid = g_stage[SHAMT_W-1].q_valid;
    assign out_data  = g_stage[SHAMT_W-1].q_data;
    assign out_tag   = g_stage[SHAMT_W-1].q_tag;

`ifdef SHIFTER_ZERO_FLAG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_zero <= 1'b0;
        end else if (advance && g_stage[SHAMT_W-1].v_in) begin
            out_zero <= (g_stage[SHAMT_W-1].shifted == '0);
        end
    end
`endif

endmodule
